// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write path (AW/W/B) among NUM_MASTERS masters.
// Optional W-stall watchdog enabled by defining AXI_WR_ARB_TIMEOUT_EN.
module axi_write_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int STRB_W         = DATA_WIDTH / 8,
  localparam int MID_W          = ID_WIDTH + IDX_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_awid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          s_awlen,
  input  logic [NUM_MASTERS*3-1:0]          s_awsize,
  input  logic [NUM_MASTERS*2-1:0]          s_awburst,
  input  logic [NUM_MASTERS-1:0]            s_awvalid,
  output logic [NUM_MASTERS-1:0]            s_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0]     s_wstrb,
  input  logic [NUM_MASTERS-1:0]            s_wlast,
  input  logic [NUM_MASTERS-1:0]            s_wvalid,
  output logic [NUM_MASTERS-1:0]            s_wready,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]   s_bid,
  output logic [NUM_MASTERS*2-1:0]          s_bresp,
  output logic [NUM_MASTERS-1:0]            s_bvalid,
  input  logic [NUM_MASTERS-1:0]            s_bready,
  output logic [MID_W-1:0]                  m_awid,
  output logic [ADDR_WIDTH-1:0]             m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [DATA_WIDTH-1:0]             m_wdata,
  output logic [STRB_W-1:0]                 m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  input  logic [MID_W-1:0]                  m_bid,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready,
  output logic                              timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [3:0]       outstanding_reg, outstanding_next;
  logic [IDX_W-1:0] rr_pick;
  logic             rr_found;
  logic             aw_hs, w_hs, b_hs;

  logic [ID_WIDTH-1:0]   awid_arr   [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] awaddr_arr [NUM_MASTERS];
  logic [7:0]            awlen_arr  [NUM_MASTERS];
  logic [2:0]            awsize_arr [NUM_MASTERS];
  logic [1:0]            awburst_arr[NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr  [NUM_MASTERS];
  logic [STRB_W-1:0]     wstrb_arr  [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign awid_arr[gi]    = s_awid[gi*ID_WIDTH +: ID_WIDTH];
      assign awaddr_arr[gi]  = s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign awlen_arr[gi]   = s_awlen[gi*8 +: 8];
      assign awsize_arr[gi]  = s_awsize[gi*3 +: 3];
      assign awburst_arr[gi] = s_awburst[gi*2 +: 2];
      assign wdata_arr[gi]   = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_arr[gi]   = s_wstrb[gi*STRB_W +: STRB_W];
    end
  endgenerate

  // First requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] idx_sel;
    rr_pick  = rr_ptr_reg;
    rr_found = 1'b0;
    idx      = 0;
    idx_sel  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      idx_sel = IDX_W'(idx);
      if (!rr_found && s_awvalid[idx_sel]) begin
        rr_found = 1'b1;
        rr_pick  = idx_sel;
      end
    end
  end

  always_comb begin
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_awvalid = 1'b0;
    s_awready = '0;
    if (state_reg == ST_ADDR) begin
      m_awid               = {grant_reg, awid_arr[grant_reg]};
      m_awaddr             = awaddr_arr[grant_reg];
      m_awlen              = awlen_arr[grant_reg];
      m_awsize             = awsize_arr[grant_reg];
      m_awburst            = awburst_arr[grant_reg];
      m_awvalid            = s_awvalid[grant_reg];
      s_awready[grant_reg] = m_awready;
    end
  end

  always_comb begin
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    m_wvalid = 1'b0;
    s_wready = '0;
    if (state_reg == ST_DATA) begin
      m_wdata             = wdata_arr[grant_reg];
      m_wstrb             = wstrb_arr[grant_reg];
      m_wlast             = s_wlast[grant_reg];
      m_wvalid            = s_wvalid[grant_reg];
      s_wready[grant_reg] = m_wready;
    end
  end

  // B routing by the index prepended to the ID; unknown indices are sunk.
  logic [IDX_W-1:0]       b_idx;
  logic [NUM_MASTERS-1:0] b_sel;
  logic                   b_idx_ok;

  assign b_idx    = m_bid[MID_W-1:ID_WIDTH];
  assign b_idx_ok = int'(b_idx) < NUM_MASTERS;

  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_broute
      assign b_sel[gi]                       = (b_idx == IDX_W'(gi));
      assign s_bvalid[gi]                    = rst_n & m_bvalid & b_sel[gi];
      assign s_bid[gi*ID_WIDTH +: ID_WIDTH]  = b_sel[gi] ? m_bid[ID_WIDTH-1:0] : '0;
      assign s_bresp[gi*2 +: 2]              = b_sel[gi] ? m_bresp : 2'b00;
    end
  endgenerate

  assign m_bready = rst_n & (b_idx_ok ? |(s_bready & b_sel) : 1'b1);

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rr_found && (outstanding_reg < 4'(MAX_OUTSTANDING))) begin
          state_next = ST_ADDR;
          grant_next = rr_pick;
        end
      end
      ST_ADDR: begin
        if (aw_hs) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_hs && m_wlast) begin
          state_next  = ST_IDLE;
          rr_ptr_next = (grant_reg == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    if (aw_hs && !b_hs) begin
      outstanding_next = outstanding_reg + 4'd1;
    end else if (!aw_hs && b_hs && (outstanding_reg != 4'd0)) begin
      outstanding_next = outstanding_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      rr_ptr_reg      <= '0;
      outstanding_reg <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      rr_ptr_reg      <= rr_ptr_next;
      outstanding_reg <= outstanding_next;
    end
  end

`ifdef AXI_WR_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_reg, wd_cnt_next;
  logic        timeout_err_reg, timeout_err_next;

  // Counter value N after the Nth consecutive stalled DATA cycle.
  always_comb begin
    wd_cnt_next      = wd_cnt_reg;
    timeout_err_next = timeout_err_reg;
    if (aw_hs || w_hs || (state_reg != ST_DATA)) begin
      wd_cnt_next = '0;
    end else if (wd_cnt_reg != 16'hFFFF) begin
      wd_cnt_next = wd_cnt_reg + 16'd1;
    end
    if ((state_reg == ST_DATA) && !w_hs && (wd_cnt_reg >= 16'(TIMEOUT_CYCLES - 1))) begin
      timeout_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wd_cnt_reg      <= wd_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: B-routing vector table plus burst sequences.
module tb_axi_write_arbiter;
  localparam int N    = 2;
  localparam int IDW  = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = DW / 8;
  localparam int MIDW = IDW + 1;
`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst_n;
  logic [N*IDW-1:0] s_awid;
  logic [N*AW-1:0]  s_awaddr;
  logic [N*8-1:0]   s_awlen;
  logic [N*3-1:0]   s_awsize;
  logic [N*2-1:0]   s_awburst;
  logic [N-1:0]     s_awvalid, s_awready;
  logic [N*DW-1:0]  s_wdata;
  logic [N*SW-1:0]  s_wstrb;
  logic [N-1:0]     s_wlast, s_wvalid, s_wready;
  logic [N*IDW-1:0] s_bid;
  logic [N*2-1:0]   s_bresp;
  logic [N-1:0]     s_bvalid, s_bready;
  logic [MIDW-1:0]  m_awid;
  logic [AW-1:0]    m_awaddr;
  logic [7:0]       m_awlen;
  logic [2:0]       m_awsize;
  logic [1:0]       m_awburst;
  logic             m_awvalid, m_awready;
  logic [DW-1:0]    m_wdata;
  logic [SW-1:0]    m_wstrb;
  logic             m_wlast, m_wvalid, m_wready;
  logic [MIDW-1:0]  m_bid;
  logic [1:0]       m_bresp;
  logic             m_bvalid, m_bready;
  logic             timeout_err;

  logic [IDW-1:0] awid_u[N];
  logic [AW-1:0]  awaddr_u[N];
  logic [7:0]     awlen_u[N];
  logic           awvalid_u[N];
  logic [DW-1:0]  wdata_u[N];
  logic           wlast_u[N];
  logic           wvalid_u[N];
  logic           awready_u[N];
  logic           wready_u[N];
  logic [IDW-1:0] sbid_u[N];
  logic [1:0]     sbresp_u[N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign s_awid[gi*IDW +: IDW]  = awid_u[gi];
      assign s_awaddr[gi*AW +: AW]  = awaddr_u[gi];
      assign s_awlen[gi*8 +: 8]     = awlen_u[gi];
      assign s_awvalid[gi]          = awvalid_u[gi];
      assign s_wdata[gi*DW +: DW]   = wdata_u[gi];
      assign s_wlast[gi]            = wlast_u[gi];
      assign s_wvalid[gi]           = wvalid_u[gi];
      assign awready_u[gi]          = s_awready[gi];
      assign wready_u[gi]           = s_wready[gi];
      assign sbid_u[gi]             = s_bid[gi*IDW +: IDW];
      assign sbresp_u[gi]           = s_bresp[gi*2 +: 2];
    end
  endgenerate
  assign s_awsize  = {N{3'd3}};
  assign s_awburst = {N{2'b01}};
  assign s_wstrb   = {N{8'hFF}};

  axi_write_arbiter #(
    .NUM_MASTERS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wpat(input int m, input int b);
    return 64'hA5A5_0000_0000_0000 | 64'(m << 8) | 64'(b);
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      awvalid_u[i] = 1'b0;
      wvalid_u[i]  = 1'b0;
      wlast_u[i]   = 1'b0;
      wdata_u[i]   = '0;
      awlen_u[i]   = '0;
    end
    awid_u[0] = 4'd3;  awaddr_u[0] = 32'h0000_1000;
    awid_u[1] = 4'd5;  awaddr_u[1] = 32'h0000_2000;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bid     = '0;
    m_bresp   = '0;
    m_bvalid  = 1'b0;
    s_bready  = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Master m issues a burst of len+1 beats; exp_lat < 0 skips the latency check.
  // abort_beat >= 0 pulls rst_n low while that beat is presented.
  task automatic do_burst(input int m, input int len, input int exp_lat, input int abort_beat);
    int lat;
    bit got;
    logic [MIDW-1:0] e_id;
    lat = 0;
    got = 1'b0;
    awlen_u[m]   = 8'(len);
    awvalid_u[m] = 1'b1;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = m_awvalid;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL aw_wait: m_awvalid still 0 after %0d cycles for master %0d, required 1", lat, m);
      awvalid_u[m] = 1'b0;
      return;
    end
    if (exp_lat >= 0) check("aw_latency", 128'(lat), 128'(exp_lat));
    e_id = {1'(m), awid_u[m]};
    check("aw_payload", {m_awid, m_awaddr, m_awlen, awready_u[m]},
          {e_id, awaddr_u[m], 8'(len), 1'b1});
    @(posedge clk);
    #1 awvalid_u[m] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wvalid_u[m] = 1'b1;
      wdata_u[m]  = wpat(m, b);
      wlast_u[m]  = (b == len);
      if (b == abort_beat) begin
        rst_n = 1'b0;
        #1 check("rst_w_drop", {m_wvalid, s_wready, m_awvalid}, '0);
        wvalid_u[m] = 1'b0;
        wlast_u[m]  = 1'b0;
        @(negedge clk);
        check("rst_idle", {m_wvalid, m_awvalid, s_awready}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("burst master=%0d len=%0d aborted by reset at beat %0d", m, len, b);
        return;
      end
      @(negedge clk);
      check("w_beat", {m_wvalid, m_wlast, wready_u[m], m_wdata, m_wstrb},
            {1'b1, (b == len), 1'b1, wpat(m, b), 8'hFF});
      @(posedge clk);
      #1;
    end
    wvalid_u[m] = 1'b0;
    wlast_u[m]  = 1'b0;
    $display("burst master=%0d len=%0d aw_latency=%0d", m, len, lat);
  endtask

  typedef struct {
    logic [MIDW-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic [N-1:0]    bready;
    logic [N-1:0]    e_bvalid;
    logic [IDW-1:0]  e_sbid;
    logic [1:0]      e_sbresp;
    logic            e_mready;
  } bvec_t;

  bvec_t btab[5];

  initial begin
    int k;
    btab[0] = '{5'h15, 2'd0, 1'b1, 2'b11, 2'b10, 4'h5, 2'd0, 1'b1};
    btab[1] = '{5'h0A, 2'd2, 1'b1, 2'b01, 2'b01, 4'hA, 2'd2, 1'b1};
    btab[2] = '{5'h0A, 2'd1, 1'b1, 2'b10, 2'b01, 4'hA, 2'd1, 1'b0};
    btab[3] = '{5'h1F, 2'd3, 1'b0, 2'b00, 2'b00, 4'hF, 2'd3, 1'b0};
    btab[4] = '{5'h13, 2'd1, 1'b1, 2'b01, 2'b10, 4'h3, 2'd1, 1'b0};

    // Reset state, with requests and a B response present to prove gating.
    rst_n = 1'b0;
    clear_inputs();
    awvalid_u[0] = 1'b1;
    wvalid_u[1]  = 1'b1;
    m_bvalid = 1'b1; m_bid = 5'h15; s_bready = 2'b11;
    #2;
    check("rst_aw", {m_awvalid, s_awready, m_awaddr, m_awid}, '0);
    check("rst_w", {m_wvalid, s_wready, m_wdata}, '0);
    check("rst_b", {s_bvalid, m_bready}, '0);
    check("rst_timeout", 128'(timeout_err), '0);
    apply_reset();

    // Single master 0 burst, issued from a negedge so latency is one cycle.
    @(negedge clk);
    do_burst(0, 4, 1, -1);
    wvalid_u[0] = 1'b1;
    #1 check("idle_after_burst", {m_awvalid, m_wvalid, s_wready}, '0);
    wvalid_u[0] = 1'b0;

    // Combinational B routing vectors, removed before each clock edge.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_bid = btab[i].bid; m_bresp = btab[i].bresp;
      m_bvalid = btab[i].bvalid; s_bready = btab[i].bready;
      k = int'(btab[i].bid[MIDW-1]);
      #1;
      check("b_route", {s_bvalid, sbid_u[k], sbresp_u[k], m_bready},
            {btab[i].e_bvalid, btab[i].e_sbid, btab[i].e_sbresp, btab[i].e_mready});
      $display("bvec %0d bid=0x%0h s_bvalid=%b m_bready=%b", i, btab[i].bid, s_bvalid, m_bready);
      m_bvalid = 1'b0; s_bready = '0;
    end

    // Both masters request continuously; B drained every cycle so the limit stays clear.
    apply_reset();
    m_bvalid = 1'b1; m_bid = 5'h00; s_bready = 2'b01;
    for (int r = 0; r < 4; r++) begin
      awvalid_u[0] = 1'b1; awvalid_u[1] = 1'b1;
      awlen_u[0] = 8'd1;   awlen_u[1] = 8'd1;
      do_burst(r % 2, 1, 2, -1);
    end
    awvalid_u[0] = 1'b0; awvalid_u[1] = 1'b0;
    m_bvalid = 1'b0; s_bready = '0;

    // Outstanding limit of 2, including a B handshake at zero (no underflow).
    apply_reset();
    m_bid = 5'h02; m_bvalid = 1'b1; s_bready = 2'b01;
    @(posedge clk);
    #1 m_bvalid = 1'b0; s_bready = '0;
    do_burst(0, 1, 2, -1);
    do_burst(1, 0, 2, -1);
    awlen_u[0] = 8'd0;
    awvalid_u[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("aw_stall_full", 128'(m_awvalid), '0);
    end
    @(negedge clk);
    m_bid = 5'h15; m_bresp = 2'd0; m_bvalid = 1'b1; s_bready = 2'b10;
    #1 check("b_two_inflight", {s_bvalid, sbid_u[1], m_bready}, {2'b10, 4'h5, 1'b1});
    @(posedge clk);
    #1 m_bvalid = 1'b0; s_bready = '0;
    @(negedge clk);
    check("aw_after_b_hs", 128'(m_awvalid), '0);
    do_burst(0, 0, 1, -1);

    // W-stall watchdog.
    apply_reset();
    m_wready = 1'b0;
    awlen_u[0] = 8'd0;
    awvalid_u[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("to_aw", {m_awvalid, m_awid}, {1'b1, 5'h03});
    @(posedge clk);
    #1 awvalid_u[0] = 1'b0;
    wvalid_u[0] = 1'b1; wlast_u[0] = 1'b1; wdata_u[0] = wpat(0, 0);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 1)   check("to_stall_wready", {m_wvalid, s_wready}, {1'b1, 2'b00});
      if (i == 255) check("to_255", 128'(timeout_err), '0);
      if (i == 256) check("to_256", 128'(timeout_err), 128'(TO_EN));
      if (i == 300) check("to_300", 128'(timeout_err), 128'(TO_EN));
    end
    m_wready = 1'b1;
    @(posedge clk);
    #1 wvalid_u[0] = 1'b0; wlast_u[0] = 1'b0;
    @(negedge clk);
    check("to_sticky", {timeout_err, m_wvalid}, {TO_EN, 1'b0});
    $display("watchdog stall of 300 cycles timeout_err=%b", timeout_err);

    // Reset during beat 2 drops the burst and clears the outstanding count.
    apply_reset();
    do_burst(0, 4, 2, 2);
    check("to_cleared", 128'(timeout_err), '0);
    do_burst(1, 0, 2, -1);
    do_burst(0, 0, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule
